// File: rtl/phv_merge_pkg.sv
// Shared encodings and widths for the PHV merge stage.
// Optional watchdog is enabled with PHV_MERGE_TIMEOUT_EN.
package phv_merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  localparam int NUM_ALU_DEF    = 8;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int MD_WIDTH_DEF   = 256;
  localparam int PHV_WIDTH      = NUM_ALU_DEF * DATA_WIDTH_DEF + MD_WIDTH_DEF;

  localparam int ERR_DROP_MD  = 0;
  localparam int ERR_DUP_LANE = 1;
  localparam int ERR_STRAY    = 2;

endpackage

// File: rtl/phv_merge_lane.sv
// One ALU lane: container register plus "result seen" sticky bit.
// clear restarts the lane for a new action; a capture in the same cycle still counts.
module phv_merge_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  sticky,
  output logic                  dup
);

  // A lane that never reports keeps the zero written on clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data   <= '0;
      sticky <= 1'b0;
    end else if (clear) begin
      sticky <= capture;
      data   <= capture ? data_in : '0;
    end else if (capture) begin
      sticky <= 1'b1;
      data   <= data_in;
    end
  end

  assign dup = capture && sticky && !clear;

endmodule

// File: rtl/phv_merge.sv
// Reassembles per-ALU container results with PHV metadata into one output PHV.
// Optional collect watchdog: define PHV_MERGE_TIMEOUT_EN.
module phv_merge
  import phv_merge_pkg::*;
#(
  parameter int NUM_ALU     = NUM_ALU_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MD_WIDTH    = MD_WIDTH_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [MD_WIDTH-1:0]                  md_in,
  input  logic                                 md_in_valid,
  output logic                                 busy,
  input  logic [NUM_ALU*DATA_WIDTH-1:0]        alu_data_in,
  input  logic [NUM_ALU-1:0]                   alu_valid_in,
  output logic [NUM_ALU*DATA_WIDTH+MD_WIDTH-1:0] phv_out,
  output logic                                 phv_out_valid,
  input  logic                                 phv_out_ready,
  output logic [2:0]                           err_pulse
);

  state_t state, state_nxt;
  logic [MD_WIDTH-1:0]           md_q;
  logic [NUM_ALU*DATA_WIDTH-1:0] lane_q, merged;
  logic [NUM_ALU-1:0]            sticky, dup, cap;
  logic                          dispatch, collecting, all_done, tmo, load;
  logic [2:0]                    err_nxt;

  assign dispatch   = (state == ST_IDLE) && md_in_valid;
  assign collecting = (state == ST_COLLECT);
  assign busy       = (state != ST_IDLE);

  for (genvar i = 0; i < NUM_ALU; i++) begin : g_lane
    assign cap[i] = alu_valid_in[i] && (dispatch || collecting);

    phv_merge_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (dispatch),
      .capture (cap[i]),
      .data_in (alu_data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .data    (lane_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .sticky  (sticky[i]),
      .dup     (dup[i])
    );

    // Results arriving on the completing cycle bypass the lane register.
    assign merged[i*DATA_WIDTH +: DATA_WIDTH] =
      cap[i] ? alu_data_in[i*DATA_WIDTH +: DATA_WIDTH] : lane_q[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign all_done = &(sticky | alu_valid_in);

`ifdef PHV_MERGE_TIMEOUT_EN
  logic [4:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !collecting) wd_cnt <= '0;
    else                       wd_cnt <= wd_cnt + 5'd1;
  end

  assign tmo = collecting && (wd_cnt == 5'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE:    if (md_in_valid) state_nxt = ST_COLLECT;
      ST_COLLECT: if (all_done || tmo) begin
                    state_nxt = ST_OUTPUT;
                    load      = 1'b1;
                  end
      ST_OUTPUT:  if (phv_out_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    err_nxt               = '0;
    err_nxt[ERR_DROP_MD]  = md_in_valid && busy;
    err_nxt[ERR_DUP_LANE] = |dup;
    err_nxt[ERR_STRAY]    = ((state == ST_IDLE) && !md_in_valid && (|alu_valid_in)) ||
                            ((state == ST_OUTPUT) && (|alu_valid_in)) || tmo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      md_q          <= '0;
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
      err_pulse     <= '0;
    end else begin
      state     <= state_nxt;
      err_pulse <= err_nxt;
      if (dispatch) md_q <= md_in;
      if (load) begin
        phv_out       <= {merged, md_q};
        phv_out_valid <= 1'b1;
      end else if ((state == ST_OUTPUT) && phv_out_ready) begin
        phv_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phv_merge.sv
// Directed bench for phv_merge: transaction-level scoreboard plus literal timing/error checks.
module tb_phv_merge;
  import phv_merge_pkg::*;

  localparam int NA = 8;
  localparam int DW = 32;
  localparam int MW = 256;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [MW-1:0]    md_in = '0;
  logic             md_in_valid = 1'b0;
  logic             busy;
  logic [NA*DW-1:0] alu_data_in = '0;
  logic [NA-1:0]    alu_valid_in = '0;
  logic [PHV_WIDTH-1:0] phv_out;
  logic             phv_out_valid;
  logic             phv_out_ready = 1'b1;
  logic [2:0]       err_pulse;

  phv_merge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .md_in         (md_in),
    .md_in_valid   (md_in_valid),
    .busy          (busy),
    .alu_data_in   (alu_data_in),
    .alu_valid_in  (alu_valid_in),
    .phv_out       (phv_out),
    .phv_out_valid (phv_out_valid),
    .phv_out_ready (phv_out_ready),
    .err_pulse     (err_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [PHV_WIDTH-1:0] act, input logic [PHV_WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: one action = md plus the last value reported on each lane since dispatch.
  logic [PHV_WIDTH-1:0] exp_q[$];
  logic [MW-1:0]        m_md;
  logic [DW-1:0]        m_lane[NA];
  logic [NA-1:0]        m_seen;
  bit                   m_collect = 0;

  function automatic logic [PHV_WIDTH-1:0] build();
    logic [PHV_WIDTH-1:0] v;
    v = '0;
    v[MW-1:0] = m_md;
    for (int i = 0; i < NA; i++) v[MW + i*DW +: DW] = m_lane[i];
    return v;
  endfunction

  task automatic dispatch(input logic [MW-1:0] md);
    md_in = md;
    md_in_valid = 1'b1;
    if (!m_collect && exp_q.size() == 0) begin
      m_collect = 1;
      m_md = md;
      m_seen = '0;
      for (int i = 0; i < NA; i++) m_lane[i] = '0;
    end
  endtask

  task automatic pulse(input int lane, input logic [DW-1:0] v);
    alu_valid_in[lane] = 1'b1;
    alu_data_in[lane*DW +: DW] = v;
    if (m_collect) begin
      m_lane[lane] = v;
      m_seen[lane] = 1'b1;
      if (&m_seen) begin
        exp_q.push_back(build());
        m_collect = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    md_in_valid = 1'b0;
    alu_valid_in = '0;
  endtask

  // Output compare: first valid cycle against the model, held cycles against the previous value.
  bit                   held = 0;
  logic [PHV_WIDTH-1:0] held_val;
  always @(negedge clk) begin
    if (rst_n && phv_out_valid) begin
      if (held) chk("phv_hold", phv_out, held_val);
      else if (exp_q.size() == 0) chk("phv_unexpected", {PHV_WIDTH{1'b0}}, {PHV_WIDTH{1'b1}});
      else chk("phv_data", phv_out, exp_q[0]);
      held = !phv_out_ready;
      held_val = phv_out;
      if (phv_out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      held = 0;
    end
  end

  logic [MW-1:0] md_a5, md_b, md_c;

  initial begin
    md_a5 = {32{8'hA5}};
    md_b  = {8{32'h1234_5678}};
    md_c  = {8{32'hDEAD_0000}};

    // Reset state
    cyc(); cyc();
    chk("rst_busy", PHV_WIDTH'(busy), '0);
    chk("rst_valid", PHV_WIDTH'(phv_out_valid), '0);
    chk("rst_err", PHV_WIDTH'(err_pulse), '0);
    chk("rst_phv", phv_out, '0);
    rst_n = 1'b1;
    cyc();

    // 1: lanes 0-3 one cycle after dispatch, lanes 4-7 three cycles after
    dispatch(md_a5); cyc();
    chk("t1_busy", PHV_WIDTH'(busy), PHV_WIDTH'(1));
    for (int i = 0; i < 4; i++) pulse(i, 32'h1000 + i);
    cyc(); cyc();
    chk("t1_valid_early", PHV_WIDTH'(phv_out_valid), '0);
    for (int i = 4; i < 8; i++) pulse(i, 32'h1000 + i);
    cyc();
    chk("t1_valid", PHV_WIDTH'(phv_out_valid), PHV_WIDTH'(1));
    chk("t1_lane7", PHV_WIDTH'(phv_out[MW + 7*DW +: DW]), PHV_WIDTH'(32'h1007));
    chk("t1_md", PHV_WIDTH'(phv_out[MW-1:0]), PHV_WIDTH'(md_a5));
    cyc();
    chk("t1_done_valid", PHV_WIDTH'(phv_out_valid), '0);
    chk("t1_done_busy", PHV_WIDTH'(busy), '0);

    // 2: downstream stalls for 5 cycles
    dispatch(md_b); cyc();
    for (int i = 0; i < NA; i++) pulse(i, 32'h2000 + i);
    phv_out_ready = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_valid", PHV_WIDTH'(phv_out_valid), PHV_WIDTH'(1));
      cyc();
    end
    chk("t2_busy_held", PHV_WIDTH'(busy), PHV_WIDTH'(1));
    phv_out_ready = 1'b1;
    cyc();
    chk("t2_idle", PHV_WIDTH'(busy), '0);

    // 3: metadata arriving while busy is dropped
    dispatch(md_c); cyc();
    dispatch(md_a5);
    for (int i = 0; i < NA; i++) pulse(i, 32'h3000 + i);
    cyc();
    chk("t3_err", PHV_WIDTH'(err_pulse), PHV_WIDTH'(3'b001));
    chk("t3_md", PHV_WIDTH'(phv_out[MW-1:0]), PHV_WIDTH'(md_c));
    cyc();

    // 4: lane 2 reports twice, second value wins
    dispatch(md_b); cyc();
    pulse(2, 32'h11); cyc();
    pulse(2, 32'h22); cyc();
    chk("t4_err", PHV_WIDTH'(err_pulse), PHV_WIDTH'(3'b010));
    for (int i = 0; i < NA; i++) if (i != 2) pulse(i, 32'h4000 + i);
    cyc();
    chk("t4_lane2", PHV_WIDTH'(phv_out[MW + 2*DW +: DW]), PHV_WIDTH'(32'h22));
    cyc();

    // 5: reset in the middle of a collect
    dispatch(md_a5); cyc();
    for (int i = 0; i < 4; i++) pulse(i, 32'h5000 + i);
    cyc();
    rst_n = 1'b0;
    m_collect = 0;
    cyc();
    rst_n = 1'b1;
    chk("t5_busy", PHV_WIDTH'(busy), '0);
    chk("t5_valid", PHV_WIDTH'(phv_out_valid), '0);
    pulse(5, 32'h55); cyc();
    chk("t5_stray", PHV_WIDTH'(err_pulse), PHV_WIDTH'(3'b100));
    // Clean PHV with every lane reporting in the dispatch cycle, plus a stray pulse while stalled
    dispatch(md_c);
    for (int i = 0; i < NA; i++) pulse(i, 32'h6000 + i);
    cyc();
    chk("t5_same_cycle_busy", PHV_WIDTH'(busy), PHV_WIDTH'(1));
    phv_out_ready = 1'b0;
    cyc();
    chk("t5_same_cycle_valid", PHV_WIDTH'(phv_out_valid), PHV_WIDTH'(1));
    pulse(1, 32'hBAD); cyc();
    chk("t5_out_stray", PHV_WIDTH'(err_pulse), PHV_WIDTH'(3'b100));
    phv_out_ready = 1'b1;
    cyc();

    // 6: lane 7 never reports
    dispatch(md_b); cyc();
    for (int i = 0; i < 7; i++) pulse(i, 32'h7000 + i);
`ifdef PHV_MERGE_TIMEOUT_EN
    m_collect = 0;
    m_lane[7] = '0;
    exp_q.push_back(build());
    cyc();
    for (int k = 0; k < 14; k++) cyc();
    chk("t6_not_yet", PHV_WIDTH'(phv_out_valid), '0);
    cyc();
    chk("t6_timeout_valid", PHV_WIDTH'(phv_out_valid), PHV_WIDTH'(1));
    chk("t6_timeout_err", PHV_WIDTH'(err_pulse), PHV_WIDTH'(3'b100));
    chk("t6_lane7", PHV_WIDTH'(phv_out[MW + 7*DW +: DW]), '0);
    cyc();
`else
    cyc();
    for (int k = 0; k < 40; k++) cyc();
    chk("t6_busy_wait", PHV_WIDTH'(busy), PHV_WIDTH'(1));
    chk("t6_no_valid", PHV_WIDTH'(phv_out_valid), '0);
    pulse(7, 32'h7007); cyc();
    chk("t6_late_valid", PHV_WIDTH'(phv_out_valid), PHV_WIDTH'(1));
    cyc();
`endif

    // Drain with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk("drain_empty", PHV_WIDTH'(exp_q.size()), '0);
    chk("end_idle", PHV_WIDTH'(busy), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
